alu_mdu: RTL and testbench

Parametrised multiply/divide unit with HI/LO registers, used as a companion to the single-cycle ALU in the EX stage of the pipelined MIPS core.
- Accepts mult/multu/div/divu and mthi/mtlo.
- Multiply and divide run for a fixed, parameter-set number of cycles, with a busy handshake toward the hazard unit.
- An exception flush suppresses the start of a new operation.

---
 rtl/alu_mdu_pkg.sv | 26 ++
 rtl/alu_mdu_core_calc.sv | 68 ++++++
 rtl/alu_mdu.sv | 118 +++++++++++
 tb/tb_alu_mdu.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_pkg.sv
// Shared encodings for the multiply/divide unit: md_op values, FSM states, helpers.
package alu_mdu_pkg;

   localparam int MD_OP_W = 3;

   typedef enum logic [MD_OP_W-1:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5,
      MD_MADD  = 3'd6,
      MD_MSUB  = 3'd7
   } md_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/alu_mdu_core_calc.sv
// Combinational result generator for alu_mdu: products, quotient/remainder and
// multiply-accumulate on latched operands, packed as {hi, lo}.
module mdu_core_calc
   import alu_mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [MD_OP_W-1:0]  op,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   input  logic [WIDTH-1:0]    hi,
   input  logic [WIDTH-1:0]    lo,
   output logic [2*WIDTH-1:0]  result
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [2*WIDTH-1:0] a_sx;
   logic signed [2*WIDTH-1:0] b_sx;
   logic signed [2*WIDTH-1:0] prod_s;
   logic        [2*WIDTH-1:0] a_zx;
   logic        [2*WIDTH-1:0] b_zx;
   logic        [2*WIDTH-1:0] prod_u;
   logic        [2*WIDTH-1:0] acc;
   logic                      div_zero;
   logic                      div_ovf;
   logic        [WIDTH-1:0]   b_safe;
   logic signed [WIDTH-1:0]   a_s;
   logic signed [WIDTH-1:0]   b_safe_s;
   logic signed [WIDTH-1:0]   quo_s;
   logic signed [WIDTH-1:0]   rem_s;
   logic        [WIDTH-1:0]   quo_u;
   logic        [WIDTH-1:0]   rem_u;

   always_comb begin
      a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
      b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
      prod_s = a_sx * b_sx;
      a_zx   = {{WIDTH{1'b0}}, a};
      b_zx   = {{WIDTH{1'b0}}, b};
      prod_u = a_zx * b_zx;
      acc    = {hi, lo};

      // A divisor of 1 on the overflow case yields exactly lo = a, hi = 0,
      // and keeps divide-by-zero away from the behavioural operators.
      div_zero = (b == '0);
      div_ovf  = (op == MD_DIV) && (a == MOST_NEG) && (b == {WIDTH{1'b1}});
      b_safe   = div_zero ? WIDTH'(1) : b;
      a_s      = a;
      b_safe_s = (div_zero || div_ovf) ? WIDTH'(1) : b;
      quo_s    = a_s / b_safe_s;
      rem_s    = a_s % b_safe_s;
      quo_u    = a / b_safe;
      rem_u    = a % b_safe;

      result = acc;
      case (op)
         MD_MULT:  result = prod_s;
         MD_MULTU: result = prod_u;
         MD_DIV:   result = div_zero ? {a, {WIDTH{1'b1}}} : {rem_s, quo_s};
         MD_DIVU:  result = div_zero ? {a, {WIDTH{1'b1}}} : {rem_u, quo_u};
         MD_MADD:  result = acc + prod_s;
         MD_MSUB:  result = acc - prod_s;
         default:  result = acc;
      endcase
   end

endmodule

// File: rtl/alu_mdu.sv
// Multiply/divide unit with HI/LO for the EX stage. Fixed-latency mult/div,
// single-cycle mthi/mtlo. Macro MDU_MADD_EN enables md_op 6/7 as madd/msub.
module alu_mdu
   import alu_mdu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [2:0]        md_op,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  hi,
   output logic [WIDTH-1:0]  lo,
   output logic              fsm_state
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

   state_e               state_q;
   state_e               state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_d;
   logic [MD_OP_W-1:0]   op_q;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic                 accept;
   logic                 launch;
   logic                 finish;
   logic                 load_hi;
   logic                 load_lo;
   logic [2*WIDTH-1:0]   result;

   // Ops that occupy the FSM; without the macro, 6/7 are accepted silently.
   function automatic logic is_run_op(input logic [MD_OP_W-1:0] op);
`ifdef MDU_MADD_EN
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) ||
             (op == MD_DIVU) || (op == MD_MADD)  || (op == MD_MSUB);
`else
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) ||
             (op == MD_DIVU);
`endif
   endfunction

   always_comb begin
      accept  = start && !flush && (state_q == IDLE);
      launch  = accept && is_run_op(md_op);
      load_hi = accept && (md_op == MD_MTHI);
      load_lo = accept && (md_op == MD_MTLO);
      finish  = (state_q == RUN) && (cnt_q == '0);
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (launch) begin
               state_d = RUN;
               cnt_d   = is_div_op(md_op) ? DIV_CNT : MULT_CNT;
            end
         end
         RUN: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done    <= 1'b0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done    <= finish;
         if (launch) begin
            op_q <= md_op;
            a_q  <= a;
            b_q  <= b;
         end
         // finish only happens in RUN, so it can never collide with mthi/mtlo.
         if (finish) begin
            {hi, lo} <= result;
         end else begin
            if (load_hi) hi <= a;
            if (load_lo) lo <= a;
         end
      end
   end

   assign busy      = (state_q == RUN);
   assign fsm_state = state_q;

   mdu_core_calc #(.WIDTH(WIDTH)) u_calc (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .hi     (hi),
      .lo     (lo),
      .result (result)
   );

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu: latency, arithmetic, divide corner
// cases, mthi/mtlo gating, reset abort, back-to-back issue and madd/msub.
module tb_alu_mdu;
   import alu_mdu_pkg::*;

   localparam int W        = 32;
   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          start = 1'b0;
   logic          flush = 1'b0;
   logic [2:0]    md_op = 3'd0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          busy;
   logic          done;
   logic          fsm_state;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int checks = 0;
   int errors = 0;
   logic [2*W-1:0] exp_q[$];

   always #5 clk = ~clk;

   alu_mdu #(.WIDTH(W), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .md_op     (md_op),
      .a         (a),
      .b         (b),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo),
      .fsm_state (fsm_state)
   );

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_hilo(input logic [2:0] op, input logic [W-1:0] val);
      start = 1'b1; md_op = op; a = val; flush = 1'b0;
      tick();
      start = 1'b0;
   endtask

   // Issues one op, then scrambles operands so any unlatched use shows up.
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         output int busy_cycles, output logic hilo_moved);
      logic [W-1:0] hi0;
      logic [W-1:0] lo0;
      tick();
      start = 1'b1; md_op = op; a = op_a; b = op_b; flush = 1'b0;
      tick();
      start = 1'b0; a = ~op_a; b = ~op_b;
      hi0 = hi; lo0 = lo;
      busy_cycles = 0; hilo_moved = 1'b0;
      while (busy === 1'b1 && busy_cycles < 200) begin
         busy_cycles++;
         if (hi !== hi0 || lo !== lo0) hilo_moved = 1'b1;
         tick();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #2 reset_n = 1'b0;
      repeat (3) tick();
      checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
      checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (fsm_state !== 1'b0) begin errors++; $display("FAIL reset_state got=%b exp=0", fsm_state); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_mult();
      int n; logic mv;
      run_op(MD_MULT, 32'hFFFFFFFF, 32'd2, n, mv);
      checks++; if (n != MULT_LAT) begin errors++; $display("FAIL mult_busy_cycles got=%0d exp=%0d", n, MULT_LAT); end
      checks++; if (mv !== 1'b0) begin errors++; $display("FAIL mult_hilo_early got=%b exp=0", mv); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done got=%b exp=1", done); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h exp=%h", hi, 32'hFFFFFFFF); end
      checks++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_lo got=%h exp=%h", lo, 32'hFFFFFFFE); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
      run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, n, mv);
      checks++; if (n != MULT_LAT) begin errors++; $display("FAIL multu_busy_cycles got=%0d exp=%0d", n, MULT_LAT); end
      checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL multu_hi got=%h exp=%h", hi, 32'h1); end
      checks++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo got=%h exp=%h", lo, 32'hFFFFFFFE); end
   endtask

   task automatic test_div();
      int n; logic mv;
      run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, n, mv);
      checks++; if (n != DIV_LAT) begin errors++; $display("FAIL div_busy_cycles got=%0d exp=%0d", n, DIV_LAT); end
      checks++; if (mv !== 1'b0) begin errors++; $display("FAIL div_hilo_early got=%b exp=0", mv); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL div_done got=%b exp=1", done); end
      checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got=%h exp=%h", lo, 32'hFFFFFFFD); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got=%h exp=%h", hi, 32'hFFFFFFFF); end
      run_op(MD_DIVU, 32'd7, 32'd2, n, mv);
      checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo got=%h exp=%h", lo, 32'd3); end
      checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi got=%h exp=%h", hi, 32'd1); end
      run_op(MD_DIV, 32'd7, 32'hFFFFFFFE, n, mv);
      checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negb_lo got=%h exp=%h", lo, 32'hFFFFFFFD); end
      checks++; if (hi !== 32'd1) begin errors++; $display("FAIL div_negb_hi got=%h exp=%h", hi, 32'd1); end
   endtask

   task automatic test_div_bounds();
      int n; logic mv;
      run_op(MD_DIV, 32'h12345678, 32'd0, n, mv);
      checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo got=%h exp=%h", lo, 32'hFFFFFFFF); end
      checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL div0_hi got=%h exp=%h", hi, 32'h12345678); end
      run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, n, mv);
      checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL divovf_lo got=%h exp=%h", lo, 32'h80000000); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divovf_hi got=%h exp=%h", hi, 32'h0); end
      run_op(MD_DIVU, 32'd5, 32'd0, n, mv);
      checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_lo got=%h exp=%h", lo, 32'hFFFFFFFF); end
      checks++; if (hi !== 32'd5) begin errors++; $display("FAIL divu0_hi got=%h exp=%h", hi, 32'd5); end
      run_op(MD_DIVU, 32'h80000000, 32'hFFFFFFFF, n, mv);
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL divu_big_lo got=%h exp=%h", lo, 32'h0); end
      checks++; if (hi !== 32'h80000000) begin errors++; $display("FAIL divu_big_hi got=%h exp=%h", hi, 32'h80000000); end
   endtask

   task automatic test_flush();
      int n;
      // flush at the accepting edge: the start is dropped
      tick();
      start = 1'b1; md_op = MD_MULT; a = 32'd3; b = 32'd5; flush = 1'b1;
      tick();
      start = 1'b0; flush = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_block_busy got=%b exp=0", busy); end
      // flush during a run does not abort it
      start = 1'b1;
      tick();
      start = 1'b0; flush = 1'b1;
      n = 0;
      while (busy === 1'b1 && n < 200) begin n++; tick(); end
      flush = 1'b0;
      checks++; if (n != MULT_LAT) begin errors++; $display("FAIL flush_run_cycles got=%0d exp=%0d", n, MULT_LAT); end
      checks++; if (lo !== 32'd15 || hi !== 32'd0) begin errors++; $display("FAIL flush_run_result got=%h_%h exp=%h_%h", hi, lo, 32'd0, 32'd15); end
   endtask

   task automatic test_mthi();
      int n;
      tick();
      start = 1'b1; md_op = MD_DIVU; a = 32'd7; b = 32'd2;
      tick();
      md_op = MD_MTHI; a = 32'hDEADBEEF;
      repeat (3) tick();
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 200) begin n++; tick(); end
      checks++; if (hi !== 32'd1) begin errors++; $display("FAIL mthi_busy_hi got=%h exp=%h", hi, 32'd1); end
      checks++; if (lo !== 32'd3) begin errors++; $display("FAIL mthi_busy_lo got=%h exp=%h", lo, 32'd3); end
      start = 1'b1; flush = 1'b1;
      tick();
      start = 1'b0; flush = 1'b0;
      checks++; if (hi !== 32'd1) begin errors++; $display("FAIL mthi_flush_hi got=%h exp=%h", hi, 32'd1); end
      write_hilo(MD_MTHI, 32'hDEADBEEF);
      checks++; if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL mthi_hi got=%h exp=%h", hi, 32'hDEADBEEF); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_busy_done got=%b%b exp=00", busy, done); end
      write_hilo(MD_MTLO, 32'h0BADF00D);
      checks++; if (lo !== 32'h0BADF00D || hi !== 32'hDEADBEEF) begin errors++; $display("FAIL mtlo got=%h_%h exp=%h_%h", hi, lo, 32'hDEADBEEF, 32'h0BADF00D); end
   endtask

   task automatic test_reset_mid();
      int n; int seen; logic mv;
      tick();
      start = 1'b1; md_op = MD_DIV; a = 32'd100; b = 32'd7;
      tick();
      start = 1'b0;
      repeat (3) tick();
      reset_n = 1'b0;
      #1;
      checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", hi, lo); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      tick();
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (done === 1'b1) seen++;
         tick();
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", seen); end
      run_op(MD_MULT, 32'd3, 32'd4, n, mv);
      checks++; if (lo !== 32'd12 || hi !== 32'd0) begin errors++; $display("FAIL rstmid_mult got=%h_%h exp=%h_%h", hi, lo, 32'd0, 32'd12); end
   endtask

   task automatic test_back_to_back();
      int n;
      logic [2*W-1:0] exp_v;
      exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFE});
      exp_q.push_back({32'h00000001, 32'hFFFFFFFE});
      tick();
      start = 1'b1; md_op = MD_MULT; a = 32'hFFFFFFFF; b = 32'd2;
      tick();
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 200) begin n++; tick(); end
      exp_v = exp_q.pop_front();
      checks++; if (done !== 1'b1 || {hi, lo} !== exp_v) begin errors++; $display("FAIL b2b_first got=%b %h exp=1 %h", done, {hi, lo}, exp_v); end
      start = 1'b1; md_op = MD_MULTU;
      tick();
      start = 1'b0;
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept got=%b%b exp=10", busy, done); end
      n = 0;
      while (busy === 1'b1 && n < 200) begin n++; tick(); end
      exp_v = exp_q.pop_front();
      checks++; if (n != MULT_LAT) begin errors++; $display("FAIL b2b_cycles got=%0d exp=%0d", n, MULT_LAT); end
      checks++; if (done !== 1'b1 || {hi, lo} !== exp_v) begin errors++; $display("FAIL b2b_second got=%b %h exp=1 %h", done, {hi, lo}, exp_v); end
   endtask

`ifdef MDU_MADD_EN
   task automatic test_madd();
      int n; logic mv;
      tick();
      write_hilo(MD_MTHI, 32'h0);
      write_hilo(MD_MTLO, 32'hFFFFFFFF);
      run_op(MD_MADD, 32'd1, 32'd1, n, mv);
      checks++; if (n != MULT_LAT) begin errors++; $display("FAIL madd_cycles got=%0d exp=%0d", n, MULT_LAT); end
      checks++; if (hi !== 32'd1 || lo !== 32'd0) begin errors++; $display("FAIL madd got=%h_%h exp=%h_%h", hi, lo, 32'd1, 32'd0); end
      run_op(MD_MSUB, 32'd1, 32'd1, n, mv);
      checks++; if (hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL msub got=%h_%h exp=%h_%h", hi, lo, 32'd0, 32'hFFFFFFFF); end
   endtask
`else
   task automatic test_madd();
      tick();
      write_hilo(MD_MTHI, 32'h11112222);
      write_hilo(MD_MTLO, 32'h33334444);
      for (int op = 6; op < 8; op++) begin
         start = 1'b1; md_op = 3'(op); a = 32'd1; b = 32'd1;
         tick();
         start = 1'b0;
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noop%0d_busy got=%b exp=0", op, busy); end
         tick();
         checks++; if (done !== 1'b0 || hi !== 32'h11112222 || lo !== 32'h33334444) begin errors++; $display("FAIL noop%0d got=%b %h_%h exp=0 %h_%h", op, done, hi, lo, 32'h11112222, 32'h33334444); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_bounds();
      test_flush();
      test_mthi();
      test_reset_mid();
      test_back_to_back();
      test_madd();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
